// File: rtl/button_bounce_gen.sv
// Mechanical push-button emulator: drives btn_out to a requested level through a burst of
// contact-bounce toggles, then holds it for a settle window. Define BOUNCE_RANDOM_EN for LFSR hold times.
module button_bounce_gen #(
  parameter int          NUM_BOUNCES   = 3,
  parameter int          HOLD_W        = 6,
  parameter int          SETTLE_CYCLES = 2048,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       negated_reset,
  input  logic       req_valid,
  input  logic       req_level,
  output logic       req_ready,
  output logic       btn_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] toggle_count
);

  localparam int                   SETTLE_W      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [7:0]           TOTAL_TOGGLES = 8'(2 * NUM_BOUNCES + 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD   = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0]  SETTLE_ONE    = SETTLE_W'(1);
  localparam logic [HOLD_W-1:0]    HOLD_ONE      = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHATTER = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                btn_q, btn_d;
  logic                done_q, done_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [HOLD_W-1:0]   hold_next;

`ifdef BOUNCE_RANDOM_EN
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR free-runs every cycle so hold lengths vary with request timing too.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  always_ff @(posedge clk) begin
    if (!negated_reset) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign hold_next = (lfsr_q[HOLD_W-1:0] == '0) ? HOLD_ONE : lfsr_q[HOLD_W-1:0];
`else
  localparam logic [HOLD_W-1:0] HOLD_FIXED = HOLD_W'(1) << (HOLD_W - 1);

  assign hold_next = HOLD_FIXED;
`endif

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and anything offered while busy is dropped, not queued.
  always_comb begin
    state_d  = state_q;
    btn_d    = btn_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_level != btn_q) begin
            btn_d = ~btn_q;
            cnt_d = 8'd1;
            if (TOTAL_TOGGLES == 8'd1) begin
              settle_d = SETTLE_LOAD;
              state_d  = ST_SETTLE;
            end else begin
              hold_d  = hold_next;
              state_d = ST_CHATTER;
            end
          end else begin
            cnt_d    = 8'd0;
            settle_d = SETTLE_LOAD;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_CHATTER: begin
        if (hold_q == HOLD_ONE) begin
          btn_d = ~btn_q;
          cnt_d = cnt_q + 8'd1;
          // An odd toggle total always lands on the requested level.
          if ((cnt_q + 8'd1) == TOTAL_TOGGLES) begin
            settle_d = SETTLE_LOAD;
            state_d  = ST_SETTLE;
          end else begin
            hold_d = hold_next;
          end
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_ONE) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q - SETTLE_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!negated_reset) begin
      state_q  <= ST_IDLE;
      btn_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 8'd0;
      hold_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      settle_q <= settle_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = ~req_ready;
  assign btn_out      = btn_q;
  assign done         = done_q;
  assign toggle_count = cnt_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Scoreboard bench for button_bounce_gen: the driver pushes expected {toggles, level, latency}
// per request; a negedge monitor checks hold lengths and pops/compares on every done pulse.
`timescale 1ns/1ps
module tb_button_bounce_gen;

  localparam int NB   = 3;
  localparam int HW   = 6;
`ifdef BOUNCE_RANDOM_EN
  localparam int SC   = 256;
`else
  localparam int SC   = 2048;
`endif
  localparam int HFIX     = 32;
  localparam int LAT_CHG  = 2 * NB * HFIX + SC;
  localparam int LAT_SAME = SC;
  localparam int W        = 25;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       negated_reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_level = 1'b0;
  logic       req_ready, btn_out, busy, done;
  logic [7:0] toggle_count;

  always #5 clk = ~clk;

  button_bounce_gen #(
    .NUM_BOUNCES(NB), .HOLD_W(HW), .SETTLE_CYCLES(SC), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .negated_reset(negated_reset), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .btn_out(btn_out), .busy(busy), .done(done),
    .toggle_count(toggle_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];
  int ivl_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int           acc_cyc = 0;
  int           last_tog = 0;
  int           obs_tog = 0;
  int           lat;
  logic         prev_btn = 1'b0;
  logic         rst_prev = 1'b1;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (!negated_reset || rst_prev) begin
      obs_tog  = 0;
      prev_btn = btn_out;
    end else begin
      if (btn_out !== prev_btn) begin
        obs_tog++;
        if (obs_tog > 1) begin
`ifdef BOUNCE_RANDOM_EN
          ivl_q.push_back(cyc - last_tog);
          check("hold_range", ((cyc - last_tog) >= 1) && ((cyc - last_tog) <= 63), 1);
`else
          check("hold_len", cyc - last_tog, HFIX);
`endif
        end
        last_tog = cyc;
        prev_btn = btn_out;
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc - acc_cyc;
          check("obs_toggles", obs_tog, e[24:17]);
          check("toggle_count", toggle_count, e[24:17]);
          check("final_level", btn_out, e[16]);
          if (e[15:0] == 16'hFFFF)
            check("latency_range", (lat >= 6 + SC) && (lat <= 6 * 63 + SC), 1);
          else
            check("latency", lat, e[15:0]);
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc = cyc + 1;
        obs_tog = 0;
      end
    end
    rst_prev = !negated_reset;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("ready_timeout", req_ready, 1);
  endtask

  task automatic send(input logic lvl, input int tog, input int lt);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_level = lvl;
    wait_ready();
    exp_q.push_back({8'(tog), lvl, 16'(lt)});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("done_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    negated_reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    negated_reset = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_btn_out"}, btn_out, 0);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_toggle_count"}, toggle_count, 0);
  endtask

  // ---------------- stimulus ----------------
  int snap;
  int ivl_a[$];

  initial begin
    repeat (3) @(posedge clk);
    #1 negated_reset = 1'b1;
    check_reset_state("reset");

`ifdef BOUNCE_RANDOM_EN
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 20; i++) begin
        send(((i % 2) == 0), 7, 16'hFFFF);
        wait_empty();
      end
      if (pass == 0) begin
        ivl_a = ivl_q;
        ivl_q.delete();
        pulse_reset();
        check_reset_state("rereset");
      end
    end
    check("ivl_count", ivl_q.size(), ivl_a.size());
    for (int i = 0; i < ivl_a.size() && i < ivl_q.size(); i++)
      check("ivl_repeat", ivl_q[i], ivl_a[i]);
`else
    // level change 0 -> 1
    send(1'b1, 7, LAT_CHG);
    wait_empty();
    // same-level request
    send(1'b1, 0, LAT_SAME);
    wait_empty();
    // change back to 0
    send(1'b0, 7, LAT_CHG);
    wait_empty();

    // busy request ignored, then accepted in the done cycle
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_level = 1'b1;
    wait_ready();
    exp_q.push_back({8'd7, 1'b1, 16'(LAT_CHG)});
    @(posedge clk); #1;
    req_level = 1'b0;
    exp_q.push_back({8'd7, 1'b0, 16'(LAT_CHG)});
    wait_ready();
    check("accept_on_done", done, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_empty();

    // abort mid-chatter after toggle 3
    send(1'b1, 7, LAT_CHG);
    begin
      int n = 0;
      while (toggle_count != 8'd3 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) check("toggle3_timeout", toggle_count, 3);
    end
    pulse_reset();
    check_reset_state("abort");
    snap = done_cnt;
    repeat (SC + 300) @(negedge clk);
    check("no_done_after_abort", done_cnt, snap);

    // normal operation after abort
    send(1'b1, 7, LAT_CHG);
    wait_empty();
    send(1'b0, 7, LAT_CHG);
    wait_empty();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
